// File: rtl/sync_fifo_v2_pkg.sv
// Shared definitions for the stream-buffer FIFOs: mode constants, clog2 helper
// and the occupancy-count width macro.
`ifndef SYNC_FIFO_CNT_W
`define SYNC_FIFO_CNT_W(d) (sync_fifo_pkg::clog2((d) + 32'sd1))
`endif

package sync_fifo_pkg;

  localparam int FIFO_STD  = 32'sd0;
  localparam int FIFO_FWFT = 32'sd1;

  function automatic int clog2(input int n);
    int v;
    int r;
    v = 32'sd1;
    r = 32'sd0;
    while (v < n) begin
      v = v * 32'sd2;
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_v2_if.sv
// Producer/consumer handshake bundle for sync_fifo_v2; the FIFO uses the slave side.
interface sync_fifo_v2_if #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8
);
  localparam int CW = `SYNC_FIFO_CNT_W(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_v2_mem.sv
// Storage array for sync_fifo_v2: synchronous write port, asynchronous read port.
module fifo_mem_2p #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO of arbitrary depth with standard or first-word-fall-through read,
// occupancy-derived flags and sticky overflow/underflow errors.
module sync_fifo_v2
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int DEPTH         = 8,
  parameter int FWFT          = FIFO_STD,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_v2_if.slave   bus
);

  localparam int CW = `SYNC_FIFO_CNT_W(DEPTH);
  localparam int PW = clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C   = CW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] PTR_LAST_C = PW'(DEPTH - 1);

  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  rd_acc_s;
  logic                  wr_acc_s;

  // Non-power-of-two depth: wrap by compare rather than letting the pointer overflow.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST_C) ? '0 : p + PW'(1);
  endfunction

  assign full_s   = (count_r == DEPTH_C);
  assign empty_s  = (count_r == '0);
  assign rd_acc_s = bus.rd_en & ~empty_s;
  assign wr_acc_s = bus.wr_en & (~full_s | rd_acc_s);

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r),
    .wdata (bus.data_in),
    .raddr (rd_ptr_r),
    .rdata (mem_rdata_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_acc_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (rd_acc_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Standard-mode output register: valid pulses for one cycle after each pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_r <= '0;
      valid_r    <= 1'b0;
    end else begin
      if (rd_acc_s) data_out_r <= mem_rdata_s;
      valid_r <= rd_acc_s;
    end
  end

  // A fresh error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.wr_en & ~wr_acc_s) overflow_r <= 1'b1;
      else if (bus.clr_err)      overflow_r <= 1'b0;
      if (bus.rd_en & ~rd_acc_s) underflow_r <= 1'b1;
      else if (bus.clr_err)      underflow_r <= 1'b0;
    end
  end

  always_comb begin
    if (FWFT == FIFO_FWFT) begin
      bus.data_out = empty_s ? '0 : mem_rdata_s;
      bus.valid    = ~empty_s;
    end else begin
      bus.data_out = data_out_r;
      bus.valid    = valid_r;
    end
  end

  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_r >= AFULL_C);
  assign bus.almost_empty = (count_r <= AEMPTY_C);
  assign bus.count        = count_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks both
// against a queue-based reference model, directed vectors and latency sequences.
module tb_sync_fifo_v2;
  import sync_fifo_pkg::*;

  localparam int DW = 12;
  localparam int DP = 5;

  logic clk;
  logic rst_n;
  logic wr_en;
  logic rd_en;
  logic clr_err;
  logic [DW-1:0] data_in;

  int n_checks;
  int n_fail;

  sync_fifo_v2_if #(.DATA_WIDTH(DW), .DEPTH(DP)) if_s ();
  sync_fifo_v2_if #(.DATA_WIDTH(DW), .DEPTH(DP)) if_f ();

  assign if_s.wr_en   = wr_en;
  assign if_s.rd_en   = rd_en;
  assign if_s.clr_err = clr_err;
  assign if_s.data_in = data_in;
  assign if_f.wr_en   = wr_en;
  assign if_f.rd_en   = rd_en;
  assign if_f.clr_err = clr_err;
  assign if_f.data_in = data_in;

  sync_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(FIFO_STD), .AFULL_THRESH(4), .AEMPTY_THRESH(1))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
  sync_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(FIFO_FWFT), .AFULL_THRESH(4), .AEMPTY_THRESH(1))
    dut_f (.clk(clk), .rst_n(rst_n), .bus(if_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus the standard-mode output register.
  logic [DW-1:0] q[$];
  bit            m_of, m_uf, m_sv;
  logic [DW-1:0] m_sd;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic w, input logic rd, input logic c,
                              input logic [DW-1:0] d);
    bit ra, wa;
    if (!r) begin
      q.delete();
      m_of = 1'b0; m_uf = 1'b0; m_sv = 1'b0; m_sd = '0;
    end else begin
      ra = rd && (q.size() > 0);
      wa = w && ((q.size() < DP) || ra);
      m_sv = ra;
      if (ra) m_sd = q.pop_front();
      if (wa) q.push_back(d);
      if (w && !wa) m_of = 1'b1; else if (c) m_of = 1'b0;
      if (rd && !ra) m_uf = 1'b1; else if (c) m_uf = 1'b0;
    end
  endtask

  task automatic check_model();
    int sz;
    sz = q.size();
    chk("std.count", if_s.count, sz);
    chk("fwft.count", if_f.count, sz);
    chk("std.empty", if_s.empty, sz == 0);
    chk("fwft.empty", if_f.empty, sz == 0);
    chk("std.full", if_s.full, sz == DP);
    chk("fwft.full", if_f.full, sz == DP);
    chk("std.afull", if_s.almost_full, sz >= 4);
    chk("fwft.afull", if_f.almost_full, sz >= 4);
    chk("std.aempty", if_s.almost_empty, sz <= 1);
    chk("fwft.aempty", if_f.almost_empty, sz <= 1);
    chk("std.overflow", if_s.overflow, m_of);
    chk("fwft.overflow", if_f.overflow, m_of);
    chk("std.underflow", if_s.underflow, m_uf);
    chk("fwft.underflow", if_f.underflow, m_uf);
    chk("std.valid", if_s.valid, m_sv);
    chk("std.data", if_s.data_out, m_sd);
    chk("fwft.valid", if_f.valid, sz > 0);
    if (sz > 0) chk("fwft.data", if_f.data_out, q[0]);
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic c,
                      input logic [DW-1:0] d);
    rst_n = r; wr_en = w; rd_en = rd; clr_err = c; data_in = d;
    @(posedge clk);
    model_update(r, w, rd, c, d);
    #1;
    check_model();
  endtask

  typedef struct {
    logic          r, w, rd, c;
    logic [DW-1:0] d;
    int            ec;
    logic          ee, ef, eof, euf;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic r, logic w, logic rd, logic c, logic [DW-1:0] d,
                              int ec, logic ee, logic ef, logic eof, logic euf);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.c = c; v.d = d;
    v.ec = ec; v.ee = ee; v.ef = ef; v.eof = eof; v.euf = euf;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;

    //            r     w     rd    clr   data        cnt  e     f     of    uf
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'hAAA, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'hBBB, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h002, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h003, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h004, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h005, 5, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h0FF, 5, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h006, 5, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 1'b0, 12'h007, 5, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 1'b1, 12'h0EE, 5, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 5, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[17] = mk(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[18] = mk(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[19] = mk(1'b1, 1'b1, 1'b1, 1'b0, 12'h009, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[20] = mk(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[21] = mk(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[22] = mk(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[23] = mk(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].c, tbl[i].d);
      chk("vec.std.count", if_s.count, tbl[i].ec);
      chk("vec.fwft.count", if_f.count, tbl[i].ec);
      chk("vec.empty", if_s.empty, tbl[i].ee);
      chk("vec.full", if_f.full, tbl[i].ef);
      chk("vec.overflow", if_s.overflow, tbl[i].eof);
      chk("vec.underflow", if_f.underflow, tbl[i].euf);
      if (i < 2) begin
        chk("rst.std.data", if_s.data_out, 0);
        chk("rst.fwft.data", if_f.data_out, 0);
        chk("rst.std.valid", if_s.valid, 0);
        chk("rst.fwft.valid", if_f.valid, 0);
      end
    end

    // Latency: FWFT shows a word right after the write; standard mode one cycle after the pop.
    step(1'b1, 1'b1, 1'b0, 1'b0, 12'h0A5);
    chk("lat.fwft.valid", if_f.valid, 1);
    chk("lat.fwft.data", if_f.data_out, 12'h0A5);
    chk("lat.std.valid0", if_s.valid, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
    chk("lat.std.valid1", if_s.valid, 1);
    chk("lat.std.data", if_s.data_out, 12'h0A5);
    chk("lat.fwft.popped", if_f.valid, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    chk("lat.std.valid2", if_s.valid, 0);
    chk("lat.std.hold", if_s.data_out, 12'h0A5);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 15) == 0),
           DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
